// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between decode/hazard logic and the mul/div unit.
// Latency: n/a (wiring only).
// Backpressure: busy is the only stall signal; start while busy is dropped.
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on the 64-bit working register.
// Latency: combinational.
// Backpressure: none.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] operand,
    input  logic [63:0] acc_in,
    output logic [63:0] acc_out
);
    logic [32:0] lhs;
    logic [32:0] rhs;
    logic [32:0] res;

    // Single 33-bit adder; subtract is add of the inverted operand plus carry-in.
    always_comb begin
        lhs     = is_div ? acc_in[63:31] : {1'b0, acc_in[63:32]};
        rhs     = {1'b0, operand} ^ {33{is_div}};
        res     = lhs + rhs + {32'd0, is_div};
        acc_out = acc_in;
        if (is_div) begin
            acc_out = res[32] ? {acc_in[62:0], 1'b0}
                              : {res[31:0], acc_in[30:0], 1'b1};
        end else begin
            acc_out = acc_in[0] ? {res, acc_in[31:1]}
                                : {1'b0, acc_in[63:32], acc_in[31:1]};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT(U)/DIV(U) sequencer with HI/LO; signed ops when MULDIV_SIGNED_EN is defined.
// Latency: start at edge T, result in HI/LO at edge T+33, done pulses the following cycle.
// Backpressure: busy high while not IDLE; start, MTHI and MTLO are ignored while busy.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    localparam logic [5:0] LAST_CNT = 6'(ITERS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;

    logic [63:0] step_out;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    muldiv_step u_step (
        .is_div  (is_div_q),
        .operand (opnd_q),
        .acc_in  (acc_q),
        .acc_out (step_out)
    );

`ifdef MULDIV_SIGNED_EN
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;
    logic rs_neg, rt_neg, op_signed;

    always_comb begin
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        rs_neg    = op_signed & bus.rs_data[31];
        rt_neg    = op_signed & bus.rt_data[31];
        rs_mag    = neg_if(bus.rs_data, rs_neg);
        rt_mag    = neg_if(bus.rt_data, rt_neg);
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (state_q == ST_IDLE && bus.start) begin
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
        end
        prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = neg_if(acc_q[31:0], neg_res_q);
        rem_fix  = neg_if(acc_q[63:32], neg_rem_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    always_comb begin
        rs_mag   = bus.rs_data;
        rt_mag   = bus.rt_data;
        prod_fix = acc_q;
        quo_fix  = acc_q[31:0];
        rem_fix  = acc_q[63:32];
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    is_div_d = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
                    dz_d     = is_div_d && (bus.rt_data == 32'd0);
                    opnd_d   = is_div_d ? rt_mag : rs_mag;
                    acc_d    = {32'd0, (is_div_d ? rs_mag : rt_mag)};
                    cnt_d    = 6'd0;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                acc_d = step_out;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            ST_FIX: begin
                // Divide-by-zero leaves the dividend in the remainder naturally; only LO is forced.
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d     = 1'b1;
                div_zero_d = dz_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, busy window, results, busy-time lockout and reset abort.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues the op, then follows it to done.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic mthi, input logic [31:0] mthi_val,
                          input int inject_at,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int          lat;
        int          busy_cnt;
        logic [31:0] hi_hold, lo_hold;
        hi_hold = mthi ? mthi_val : bus.hi;
        lo_hold = bus.lo;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.hi_we   = mthi;
        bus.wdata   = mthi_val;
        lat      = 99;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            if (i == inject_at) begin
                bus.start   = 1'b1;
                bus.op      = OP_DIVU;
                bus.rs_data = 32'd1;
                bus.rt_data = 32'd1;
                bus.hi_we   = 1'b1;
                bus.wdata   = 32'h0000_AAAA;
            end
            if (i == 10) begin
                check({tag, ".hold_hi"}, bus.hi, hi_hold);
                check({tag, ".hold_lo"}, bus.lo, lo_hold);
            end
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, ".busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".lo"}, bus.lo, exp_lo);
        check({tag, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
    endtask

    initial begin
        int saw_done;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.done", {31'd0, bus.done}, 32'd0);
        check("rst.div_zero", {31'd0, bus.div_zero}, 32'd0);
        check("rst.hi", bus.hi, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, -1,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        // Issued in the done cycle of the previous op.
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, -1, 32'd2, 32'd14, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, 32'd0, -1,
               32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h10, 1'b0, 32'd0, -1,
               32'h0000_0001, 32'h2345_6780, 1'b0);
        run_op("divu_by1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, -1,
               32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_small", OP_DIVU, 32'd5, 32'd9, 1'b0, 32'd0, -1, 32'd5, 32'd0, 1'b0);
        run_op("busy_ignore", OP_MULTU, 32'd3, 32'd5, 1'b0, 32'd0, 5, 32'd0, 32'd15, 1'b0);
        run_op("mthi_with_start", OP_MULTU, 32'd2, 32'd3, 1'b1, 32'h1234_5678, -1,
               32'd0, 32'd6, 1'b0);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_neg3_7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_neg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, -1,
               32'd0, 32'h8000_0000, 1'b0);
`else
        run_op("mult_unsigned", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, -1,
               32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
        run_op("div_unsigned", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, -1,
               32'd1, 32'h7FFF_FFFC, 1'b0);
        run_op("div_min_unsigned", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, -1,
               32'h8000_0000, 32'd0, 1'b0);
`endif
        run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFF8, 32'd0, 1'b0, 32'd0, -1,
               32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);

        // Abort with reset around iteration 10.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_MULTU;
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort.busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.hi", bus.hi, 32'd0);
        check("abort.lo", bus.lo, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1;
        end
        check("abort.no_done", 32'(saw_done), 32'd0);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo.lo", bus.lo, 32'h0000_0055);
        check("mtlo.hi", bus.hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
